// File: rtl/game_timer_pkg.sv
// game_timer_pkg: state encoding, default parameters and the
// binary-to-BCD helper shared by the game timer blocks.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF  = 5000;
  localparam int TIME_INIT_DEF = 1800000;
  localparam int TIME_W_DEF    = 21;
  localparam int PENALTY_DEF   = 10;
  localparam int NREQ_DEF      = 4;

  // Double-dabble: adjust each digit, then shift in one bit.
  function automatic logic [31:0] to_bcd(input logic [31:0] bin);
    logic [63:0] sh;
    sh = {32'd0, bin};
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < 8; d++) begin
        if (sh[32+4*d +: 4] >= 4'd5)
          sh[32+4*d +: 4] = sh[32+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[63:32];
  endfunction

endpackage

// File: rtl/game_timer_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating start
// pointer that moves past the most recent winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant_onehot
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant_onehot = '0;
    ptr_d        = ptr_q;
    found        = 1'b0;
    idx          = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (enable && !found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        ptr_d             = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: countdown session FSM, tick prescaler and miss
// penalty arbitration. GAME_TIMER_BCD_EN adds a BCD time output.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int TIME_INIT = TIME_INIT_DEF,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int PENALTY   = PENALTY_DEF,
  parameter int NREQ      = NREQ_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [NREQ-1:0]   miss_req,
  output logic [NREQ-1:0]   miss_ack,
  output logic [TIME_W-1:0] time_left,
  output logic              tick,
  output logic [1:0]        state,
  output logic              game_over
`ifdef GAME_TIMER_BCD_EN
  ,
  output logic [31:0]       bcd_digits
`endif
);

  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [PW-1:0]     PRE_TC = PW'(TICK_DIV);
  localparam logic [TIME_W:0]   PEN_W  = (TIME_W + 1)'(PENALTY);
  localparam logic [TIME_W-1:0] INIT_W = TIME_W'(TIME_INIT);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              tick_q, tick_d;
  logic              over_q, over_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [NREQ-1:0]   grant;
  logic              arb_en;
  logic              freeze_hit;
  logic              resume_hit;
  logic              run_upd;
  logic              term;
  logic [TIME_W:0]   dec;
  logic [TIME_W:0]   time_ext;

  // Entering PAUSE freezes everything, including the arbiter.
  assign freeze_hit = (state_q == ST_RUN) && pause && !start;
  assign arb_en     = (state_q != ST_PAUSE) && !freeze_hit;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (miss_req),
    .enable      (arb_en),
    .grant_onehot(grant)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    pre_d      = pre_q;
    tick_d     = 1'b0;
    resume_hit = (state_q == ST_PAUSE) && pause && !start;
    run_upd    = (state_q == ST_RUN) && !start && !pause;
    term       = (pre_q == PRE_TC);
    time_ext   = {1'b0, time_q};
    dec        = {{TIME_W{1'b0}}, term};
    if (|grant) begin
      dec = dec + PEN_W;
    end
    unique case (1'b1)
      start: begin
        state_d = ST_RUN;
        time_d  = INIT_W;
        pre_d   = '0;
      end
      freeze_hit: state_d = ST_PAUSE;
      resume_hit: state_d = ST_RUN;
      run_upd: begin
        tick_d = term;
        pre_d  = term ? '0 : pre_q + PW'(1);
        if (time_ext > dec) begin
          time_d = TIME_W'(time_ext - dec);
        end else begin
          time_d  = '0;
          state_d = ST_OVER;
        end
      end
      default: ;
    endcase
    over_d = (state_d == ST_OVER);
    ack_d  = grant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      over_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      over_q  <= over_d;
      ack_q   <= ack_d;
    end
  end

  assign miss_ack  = ack_q;
  assign time_left = time_q;
  assign tick      = tick_q;
  assign state     = state_q;
  assign game_over = over_q;

`ifdef GAME_TIMER_BCD_EN
  logic [31:0] bcd_q, bcd_d;
  logic [63:0] time_wide;

  always_comb begin
    time_wide = 64'(time_q);
    if (time_wide > 64'd99999999) begin
      bcd_d = 32'h9999_9999;
    end else begin
      bcd_d = to_bcd(time_wide[31:0]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd_digits = bcd_q;
`endif

endmodule
